avalon_burst_slave_bram: RTL and testbench
==========================================

Name: avalon_burst_slave_bram

Overview:
- Avalon-MM burst slave (responder) that terminates f2sdram-style burst transactions from a core-side master into a simple single-port synchronous memory (BRAM/M10K).
- Used as an on-chip stand-in for the f2sdram port, and as the target for bench-level checking of masters and bus terminators.
- Handles one transaction at a time: linear write bursts and linear read bursts, with address increment, waitrequest and readdatavalid generation.

Parameters:
- DATA_WIDTH, 64, data bus width in bits (multiple of 8).
- BURSTCOUNT_WIDTH, 8, burstcount width; max burst is 2^BURSTCOUNT_WIDTH-1.
- MEM_ADDR_WIDTH, 10, memory word-address width; Avalon address is truncated to this.
- MEM_LATENCY, 2, memory read latency in cycles, mem_re to mem_rdata valid; legal range 1..3.

Ports:
- clk  in  1  single clock for bus and memory.
- rst_n  in  1  asynchronous active-low reset.
- waitrequest  out  1  Avalon stall; registered.
- burstcount  in  BURSTCOUNT_WIDTH  beats in burst; sampled on command accept.
- address  in  32-log2(DATA_WIDTH/8)  word address; sampled on command accept.
- readdata  out  DATA_WIDTH  read beat data; equals mem_rdata.
- readdatavalid  out  1  read beat valid.
- read  in  1  read command.
- writedata  in  DATA_WIDTH  write beat data.
- byteenable  in  DATA_WIDTH/8  write byte lanes.
- write  in  1  write command/beat.
- mem_addr  out  MEM_ADDR_WIDTH  memory word address.
- mem_wdata  out  DATA_WIDTH  memory write data (equals writedata).
- mem_be  out  DATA_WIDTH/8  memory byte enables (equals byteenable).
- mem_we  out  1  memory write strobe.
- mem_re  out  1  memory read strobe.
- mem_rdata  in  DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after mem_re.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, waitrequest=1, readdatavalid=0, mem_we=0, mem_re=0, proto_err=0.
  - Counters, address latch and readdatavalid shift register are cleared.
  - First posedge after release: waitrequest=0.
- States are IDLE, WRITE_BURST and READ_BURST.
- IDLE, waitrequest=0:
  - write=1: beat 0 is accepted this cycle. Combinationally mem_we=1, mem_addr=address[MEM_ADDR_WIDTH-1:0]. Latch addr+1 and remaining=burstcount-1. If remaining>0, go to WRITE_BURST; else stay in IDLE.
  - read=1 (write=0): latch address and burstcount, go to READ_BURST. waitrequest=1 from the next cycle.
  - read=1 and write=1 together: write wins, proto_err set.
  - burstcount=0 on accept: treated as 1, proto_err set.
- WRITE_BURST, waitrequest=0:
  - Each cycle with write=1 is one beat: mem_we=1, mem_addr=latched addr, then addr+1 and remaining-1. Go to IDLE after the beat that makes remaining 0.
  - write=0: stall with no memory write and no state change.
  - byteenable=0 still counts as a beat (mem_we=1, mem_be=0).
  - read=1 in this state is ignored and sets proto_err.
- READ_BURST, waitrequest=1:
  - Issue phase: mem_re=1 for N consecutive cycles starting the cycle after accept, with addresses a, a+1, ..., a+N-1.
  - readdatavalid is mem_re delayed by exactly MEM_LATENCY cycles; readdata=mem_rdata.
  - Return to IDLE (waitrequest=0) the cycle after the last readdatavalid. With accept at cycle T, the last valid beat is at T+N+MEM_LATENCY and waitrequest falls at T+N+MEM_LATENCY+1.
  - No overlap: a new command is never accepted while reads are in flight.
- Address arithmetic:
  - Modulo 2^MEM_ADDR_WIDTH; a burst crossing the top wraps to 0 silently (not an error).
  - Address upper bits above MEM_ADDR_WIDTH are ignored.
- Reset mid-burst:
  - Immediate return to IDLE.
  - Pending readdatavalid beats are dropped.
  - Partially written burst data remains in memory.
- proto_err is cleared only by rst_n.
- mem_we and mem_re are never asserted in the same cycle.

Test Plan:
- Single write then single read: write addr 0x005, be=0xFF, data 0x1122334455667788, burstcount=1 → mem_we one cycle at 0x005. Then read burstcount=1 accepted at T → readdatavalid at T+3 (L=2) with 0x1122334455667788; waitrequest high T+1..T+3, low at T+4.
- Write burst of 4 at 0x3FE with a 2-cycle write=0 gap after beat 1 → mem_we at 0x3FE, 0x3FF, 0x000, 0x001 (wrap), no writes during gap, state IDLE after beat 3, proto_err=0.
- Read burst of 8 at 0x010 → 8 consecutive readdatavalid beats matching preloaded 0x010..0x017, no gaps; waitrequest returns low exactly 1 cycle after the 8th beat.
- Violations: read+write asserted together in IDLE → write performed, proto_err=1. Burstcount=0 write → exactly one beat written. proto_err stays 1 until reset.
- Reset during read burst of 16 after 5 valid beats: rst_n low 1 cycle → readdatavalid=0 immediately and no further beats; waitrequest=1 during reset, 0 on the first clock after release. A subsequent write is accepted normally.
- Byteenable handling: write 0xFFFF..FF with be=0x0F, then read → upper 4 bytes retain prior content. A write with be=0x00 counts as a beat with no data change.

Source files
------------

// File: rtl/avalon_burst_slave_bram.sv
// ---------------------------------------------------------------------------
// avalon_burst_slave_bram
//
// Avalon-MM burst responder that terminates linear read and write bursts
// into a simple single-port synchronous memory (BRAM/M10K). It stands in
// for an f2sdram port on chip and serves as a target for checking masters.
// Only one transaction is in progress at a time.
//
// Ports
//   clk            single clock for bus and memory
//   rst_n          asynchronous active-low reset
//   waitrequest    registered Avalon stall
//   burstcount     beats in burst, sampled on command accept
//   address        word address, sampled on command accept
//   readdata       read beat data (straight from mem_rdata)
//   readdatavalid  read beat valid
//   read           read command
//   writedata      write beat data
//   byteenable     write byte lanes
//   write          write command / beat
//   mem_addr       memory word address
//   mem_wdata      memory write data
//   mem_be         memory byte enables
//   mem_we         memory write strobe
//   mem_re         memory read strobe
//   mem_rdata      memory read data, valid MEM_LATENCY cycles after mem_re
//   proto_err      sticky protocol-violation flag
// ---------------------------------------------------------------------------
module avalon_burst_slave_bram #(
  parameter int DATA_WIDTH       = 64,
  parameter int BURSTCOUNT_WIDTH = 8,
  parameter int MEM_ADDR_WIDTH   = 10,
  parameter int MEM_LATENCY      = 2,
  localparam int BE_WIDTH   = DATA_WIDTH / 8,
  localparam int ADDR_WIDTH = 32 - $clog2(DATA_WIDTH / 8)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        waitrequest,
  input  logic [BURSTCOUNT_WIDTH-1:0] burstcount,
  input  logic [ADDR_WIDTH-1:0]       address,
  output logic [DATA_WIDTH-1:0]       readdata,
  output logic                        readdatavalid,
  input  logic                        read,
  input  logic [DATA_WIDTH-1:0]       writedata,
  input  logic [BE_WIDTH-1:0]         byteenable,
  input  logic                        write,
  output logic [MEM_ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]       mem_wdata,
  output logic [BE_WIDTH-1:0]         mem_be,
  output logic                        mem_we,
  output logic                        mem_re,
  input  logic [DATA_WIDTH-1:0]       mem_rdata,
  output logic                        proto_err
);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] WRITE_BURST = 2'd1;
  localparam logic [1:0] READ_BURST  = 2'd2;

  logic [1:0]                  state;
  logic [MEM_ADDR_WIDTH-1:0]   addr_q;
  logic [BURSTCOUNT_WIDTH-1:0] remaining;
  logic [BURSTCOUNT_WIDTH-1:0] issue_cnt;
  logic [BURSTCOUNT_WIDTH-1:0] pending;
  logic [MEM_LATENCY-1:0]      rdv_sr;

  logic [BURSTCOUNT_WIDTH-1:0] bc_eff;
  logic                        cmd_accept;
  logic                        wr_accept;
  logic                        rd_accept;

  // Upper Avalon address bits are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address[ADDR_WIDTH-1:MEM_ADDR_WIDTH];

  assign readdata      = mem_rdata;
  assign mem_wdata     = writedata;
  assign mem_be        = byteenable;
  // readdatavalid is mem_re delayed by exactly MEM_LATENCY cycles.
  assign readdatavalid = rdv_sr[MEM_LATENCY-1];

  // Beat 0 of a write goes to memory in the accept cycle, so the memory
  // address comes straight from the bus while idle; afterwards the latched
  // incrementing address drives it. A zero burstcount behaves as one beat.
  always_comb begin
    bc_eff     = (burstcount == '0) ? BURSTCOUNT_WIDTH'(1) : burstcount;
    cmd_accept = (state == IDLE) && !waitrequest;
    wr_accept  = cmd_accept && write;
    rd_accept  = cmd_accept && read && !write;
    mem_we     = wr_accept || ((state == WRITE_BURST) && write);
    mem_re     = (state == READ_BURST) && (issue_cnt != '0);
    mem_addr   = (state == IDLE) ? address[MEM_ADDR_WIDTH-1:0] : addr_q;
  end

  // Read bursts keep two counters: issue_cnt for strobes still to send and
  // pending for beats still to come back. The burst ends, and waitrequest
  // drops, on the edge after the last returned beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      waitrequest <= 1'b1;
      addr_q      <= '0;
      remaining   <= '0;
      issue_cnt   <= '0;
      pending     <= '0;
      rdv_sr      <= '0;
      proto_err   <= 1'b0;
    end else begin
      rdv_sr <= (rdv_sr << 1) | MEM_LATENCY'(mem_re);
      case (state)
        IDLE: begin
          waitrequest <= 1'b0;
          if (wr_accept) begin
            addr_q    <= address[MEM_ADDR_WIDTH-1:0] + MEM_ADDR_WIDTH'(1);
            remaining <= bc_eff - BURSTCOUNT_WIDTH'(1);
            if (bc_eff != BURSTCOUNT_WIDTH'(1)) begin
              state <= WRITE_BURST;
            end
            if (read || (burstcount == '0)) begin
              proto_err <= 1'b1;
            end
          end else if (rd_accept) begin
            addr_q      <= address[MEM_ADDR_WIDTH-1:0];
            issue_cnt   <= bc_eff;
            pending     <= bc_eff;
            state       <= READ_BURST;
            waitrequest <= 1'b1;
            if (burstcount == '0) begin
              proto_err <= 1'b1;
            end
          end
        end
        WRITE_BURST: begin
          if (read) begin
            proto_err <= 1'b1;
          end
          if (write) begin
            addr_q    <= addr_q + MEM_ADDR_WIDTH'(1);
            remaining <= remaining - BURSTCOUNT_WIDTH'(1);
            if (remaining == BURSTCOUNT_WIDTH'(1)) begin
              state <= IDLE;
            end
          end
        end
        READ_BURST: begin
          if (mem_re) begin
            addr_q    <= addr_q + MEM_ADDR_WIDTH'(1);
            issue_cnt <= issue_cnt - BURSTCOUNT_WIDTH'(1);
          end
          if (readdatavalid) begin
            pending <= pending - BURSTCOUNT_WIDTH'(1);
            if (pending == BURSTCOUNT_WIDTH'(1)) begin
              state       <= IDLE;
              waitrequest <= 1'b0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          waitrequest <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_burst_slave_bram.sv
// ---------------------------------------------------------------------------
// tb_avalon_burst_slave_bram
//
// Self-checking bench for avalon_burst_slave_bram. The bench owns the BRAM
// the DUT drives, keeps a word-level reference memory updated from each
// write burst, and checks write strobes, read data, read timing,
// waitrequest, reset behaviour and the sticky protocol-error flag.
// ---------------------------------------------------------------------------
module tb_avalon_burst_slave_bram;

  localparam int DW    = 64;
  localparam int BCW   = 8;
  localparam int MAW   = 10;
  localparam int LAT   = 2;
  localparam int BEW   = DW / 8;
  localparam int AW    = 29;
  localparam int DEPTH = 1 << MAW;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           waitrequest;
  logic [BCW-1:0] burstcount;
  logic [AW-1:0]  address;
  logic [DW-1:0]  readdata;
  logic           readdatavalid;
  logic           read;
  logic [DW-1:0]  writedata;
  logic [BEW-1:0] byteenable;
  logic           write;
  logic [MAW-1:0] mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic [BEW-1:0] mem_be;
  logic           mem_we;
  logic           mem_re;
  logic [DW-1:0]  mem_rdata;
  logic           proto_err;

  always #5 clk = ~clk;

  avalon_burst_slave_bram #(
    .DATA_WIDTH(DW), .BURSTCOUNT_WIDTH(BCW), .MEM_ADDR_WIDTH(MAW), .MEM_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .waitrequest(waitrequest), .burstcount(burstcount),
    .address(address), .readdata(readdata), .readdatavalid(readdatavalid),
    .read(read), .writedata(writedata), .byteenable(byteenable), .write(write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata), .proto_err(proto_err)
  );

  // Bench-owned BRAM with byte-lane writes and a LAT-deep read pipeline.
  logic [DW-1:0] bram [DEPTH];
  logic [DW-1:0] rd_pipe [LAT];
  logic          clear_mem;

  always @(posedge clk) begin
    if (clear_mem) begin
      for (int i = 0; i < DEPTH; i++) bram[i] <= '0;
    end else if (mem_we) begin
      for (int b = 0; b < BEW; b++)
        if (mem_be[b]) bram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    if (mem_re) rd_pipe[0] <= bram[mem_addr];
    for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  // Cycle counter and negedge monitor logging bus/memory events.
  int            cyc = 0;
  int            we_addr[$];
  logic [DW-1:0] we_data[$];
  logic [DW-1:0] rdv_data[$];
  int            rdv_cyc[$];
  int            wr_fall[$];
  int            both_cnt = 0;
  logic          prev_wr = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      we_addr.push_back(int'(mem_addr));
      we_data.push_back(mem_wdata);
    end
    if (readdatavalid) begin
      rdv_data.push_back(readdata);
      rdv_cyc.push_back(cyc);
    end
    if (prev_wr && !waitrequest) wr_fall.push_back(cyc);
    if (mem_we && mem_re) both_cnt++;
    prev_wr = waitrequest;
  end

  // Reference model: word array updated beat by beat with byte merging.
  logic [DW-1:0]  ref_mem [DEPTH];
  logic [DW-1:0]  beat_data [256];
  logic [BEW-1:0] beat_be [256];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_output(input string tag, input logic [DW-1:0] observed,
                              input logic [DW-1:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic fill_beats(input int n, input bit random_be);
    for (int i = 0; i < n; i++) begin
      beat_data[i] = {$urandom(), $urandom()};
      beat_be[i]   = random_be ? BEW'($urandom()) : '1;
    end
  endtask

  task automatic apply_stimulus_write(input logic [AW-1:0] a, input logic [BCW-1:0] bc,
                                      input int gap_after, input int gap_len,
                                      input bit with_read, input bit exp_err);
    int n    = (bc == 0) ? 1 : int'(bc);
    int base = we_addr.size();
    int a_lo = int'(a) % DEPTH;
    int cnt;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      write      = 1'b1;
      read       = (i == 0) && with_read;
      address    = a;
      burstcount = bc;
      writedata  = beat_data[i];
      byteenable = beat_be[i];
      for (int b = 0; b < BEW; b++)
        if (beat_be[i][b]) ref_mem[(a_lo + i) % DEPTH][8*b +: 8] = beat_data[i][8*b +: 8];
      if (i == gap_after) begin
        repeat (gap_len) begin
          @(posedge clk); #1;
          write = 1'b0;
          read  = 1'b0;
        end
      end
    end
    @(posedge clk); #1;
    write     = 1'b0;
    read      = 1'b0;
    writedata = {$urandom(), $urandom()};
    cnt = we_addr.size() - base;
    check_output("wr_beat_count", cnt, n);
    for (int i = 0; i < n && i < cnt; i++) begin
      check_output("wr_addr", we_addr[base+i], (a_lo + i) % DEPTH);
      check_output("wr_data", we_data[base+i], beat_data[i]);
    end
    check_output("wr_proto_err", proto_err, exp_err);
  endtask

  task automatic apply_stimulus_read(input logic [AW-1:0] a, input logic [BCW-1:0] bc);
    int n       = (bc == 0) ? 1 : int'(bc);
    int rd_base = rdv_data.size();
    int wf_base = wr_fall.size();
    int a_lo    = int'(a) % DEPTH;
    int budget  = n + LAT + 30;
    int t_acc;
    int cnt;
    @(posedge clk); #1;
    read       = 1'b1;
    address    = a;
    burstcount = bc;
    t_acc      = cyc;
    @(posedge clk); #1;
    read = 1'b0;
    check_output("rd_wait_high", waitrequest, 1'b1);
    while (((rdv_data.size() - rd_base) < n || (wr_fall.size() - wf_base) < 1) && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check_output("rd_timeout", budget > 0, 1'b1);
    cnt = rdv_data.size() - rd_base;
    check_output("rd_beat_count", cnt, n);
    for (int i = 0; i < n && i < cnt; i++) begin
      check_output("rd_data", rdv_data[rd_base+i], ref_mem[(a_lo + i) % DEPTH]);
      check_output("rd_beat_cycle", rdv_cyc[rd_base+i], t_acc + 1 + LAT + i);
    end
    if (wr_fall.size() > wf_base)
      check_output("rd_wait_fall", wr_fall[wf_base], t_acc + n + LAT + 1);
  endtask

  initial begin
    int rd_base;
    int budget;
    logic [AW-1:0] ra;
    int rn;

    rst_n      = 1'b1;
    read       = 1'b0;
    write      = 1'b0;
    address    = '0;
    burstcount = 8'd1;
    writedata  = '0;
    byteenable = '0;
    clear_mem  = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    // Reset values.
    #2 rst_n = 1'b0;
    #1;
    check_output("rst_waitrequest", waitrequest, 1'b1);
    check_output("rst_rdv", readdatavalid, 1'b0);
    check_output("rst_mem_we", mem_we, 1'b0);
    check_output("rst_mem_re", mem_re, 1'b0);
    check_output("rst_proto_err", proto_err, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    clear_mem = 1'b0;
    rst_n     = 1'b1;
    @(posedge clk); #1;
    check_output("wait_low_after_rst", waitrequest, 1'b0);

    // Single write then single read.
    beat_data[0] = 64'h1122334455667788;
    beat_be[0]   = 8'hFF;
    apply_stimulus_write(29'h005, 8'd1, -1, 0, 1'b0, 1'b0);
    apply_stimulus_read(29'h005, 8'd1);
    check_output("single_rd_value", rdv_data[rdv_data.size()-1], 64'h1122334455667788);

    // Burst of 4 crossing the top of memory, 2-cycle gap after beat 1.
    fill_beats(4, 1'b0);
    apply_stimulus_write(29'h3FE, 8'd4, 1, 2, 1'b0, 1'b0);
    apply_stimulus_read(29'h3FE, 8'd4);

    // Preload 0x010..0x017 and read it back as one burst of 8.
    fill_beats(8, 1'b0);
    apply_stimulus_write(29'h010, 8'd8, -1, 0, 1'b0, 1'b0);
    apply_stimulus_read(29'h010, 8'd8);

    // Byte enables: partial write keeps upper bytes, be=0 still a beat.
    fill_beats(2, 1'b0);
    apply_stimulus_write(29'h020, 8'd2, -1, 0, 1'b0, 1'b0);
    beat_data[0] = '1;
    beat_be[0]   = 8'h0F;
    apply_stimulus_write(29'h020, 8'd1, -1, 0, 1'b0, 1'b0);
    beat_data[0] = {$urandom(), $urandom()};
    beat_be[0]   = 8'h00;
    apply_stimulus_write(29'h021, 8'd1, -1, 0, 1'b0, 1'b0);
    apply_stimulus_read(29'h020, 8'd2);

    // Upper address bits are ignored.
    fill_beats(2, 1'b0);
    apply_stimulus_write(29'h0ABCD030, 8'd2, -1, 0, 1'b0, 1'b0);
    apply_stimulus_read(29'h00000030, 8'd2);

    // Randomized bursts with random byte enables and gaps.
    for (int it = 0; it < 6; it++) begin
      ra = AW'($urandom());
      rn = int'($urandom_range(1, 6));
      fill_beats(rn, 1'b1);
      apply_stimulus_write(ra, BCW'(rn), int'($urandom_range(0, rn - 1)),
                           int'($urandom_range(0, 2)), 1'b0, 1'b0);
      apply_stimulus_read(ra, BCW'(rn));
    end

    // Protocol violations: read+write together, then burstcount 0.
    check_output("proto_err_clean", proto_err, 1'b0);
    fill_beats(1, 1'b0);
    apply_stimulus_write(29'h100, 8'd1, -1, 0, 1'b1, 1'b1);
    fill_beats(1, 1'b0);
    apply_stimulus_write(29'h104, 8'd0, -1, 0, 1'b0, 1'b1);
    apply_stimulus_read(29'h100, 8'd1);
    apply_stimulus_read(29'h104, 8'd1);
    check_output("proto_err_sticky", proto_err, 1'b1);

    // Reset during a read burst of 16 after 5 returned beats.
    rd_base = rdv_data.size();
    @(posedge clk); #1;
    read       = 1'b1;
    address    = 29'h200;
    burstcount = 8'd16;
    @(posedge clk); #1;
    read   = 1'b0;
    budget = 40;
    while ((rdv_data.size() - rd_base) < 5 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check_output("mid_rst_timeout", budget > 0, 1'b1);
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_rdv", readdatavalid, 1'b0);
    check_output("mid_rst_wait", waitrequest, 1'b1);
    check_output("mid_rst_proto_err", proto_err, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_output("rel_wait_before_edge", waitrequest, 1'b1);
    @(posedge clk); #1;
    check_output("rel_wait_after_edge", waitrequest, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check_output("mid_rst_no_more_beats", rdv_data.size() - rd_base, 5);

    // A normal write and read after the reset.
    fill_beats(3, 1'b0);
    apply_stimulus_write(29'h205, 8'd3, -1, 0, 1'b0, 1'b0);
    apply_stimulus_read(29'h205, 8'd3);

    check_output("we_re_exclusive", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
